ip_reg_target: RTL and testbench

IP_REG_TARGET -- requirements
Module: ip_reg_target

---
 rtl/ip_reg_target.sv | 155 +++++++++++++++
 tb/tb_ip_reg_target.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_reg_target.sv
// Register target for the DMA core: a four-state request/ack handshake in front of
// ID, SCRATCH, CONTROL, STATUS, interrupt status/enable and an event counter.
module ip_reg_target #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5043_4944
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        registerSelectB,
    input  logic        registerReadB,
    input  logic [31:0] registerAddressB,
    input  logic [31:0] registerWriteDataB,
    output logic        registerAckB,
    output logic        registerErrorB,
    output logic [31:0] registerReadDataB,
    input  logic [31:0] statusIn,
    input  logic [7:0]  intEvent,
    output logic [7:0]  control,
    output logic        intOut
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} stateT;

    stateT       state;
    logic [31:0] scratch;
    logic [7:0]  intStatus;
    logic [7:0]  intEnable;
    logic [31:0] eventCount;
    logic [31:0] holdData;
    logic        holdError;

    logic [4:0]  offset;
    logic        inRange;
    logic        accessError;
    logic        commit;
    logic        writeCommit;
    logic [31:0] readValue;
    logic [7:0]  intClearMask;
    logic        countClear;

    function automatic logic [3:0] popCount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign offset      = registerAddressB[4:0];
    assign inRange     = (registerAddressB[31:5] == BASE_ADDR[31:5]);
    assign commit      = (state == ACCESS) && registerSelectB;
    assign writeCommit = commit && !registerReadB && !accessError;

    always_comb begin
        accessError = !inRange
                   || (offset[1:0] != 2'b00)
                   || (offset == 5'h1C)
                   || (!registerReadB && ((offset == 5'h00) || (offset == 5'h0C)));
    end

    always_comb begin
        readValue = 32'h0;
        case (offset)
            5'h00:   readValue = ID_VALUE;
            5'h04:   readValue = scratch;
            5'h08:   readValue = {24'h0, control};
            5'h0C:   readValue = statusIn;
            5'h10:   readValue = {24'h0, intStatus};
            5'h14:   readValue = {24'h0, intEnable};
            5'h18:   readValue = eventCount;
            default: readValue = 32'h0;
        endcase
    end

    always_comb begin
        intClearMask = 8'h00;
        countClear   = 1'b0;
        if (writeCommit && (offset == 5'h10)) begin
            intClearMask = registerWriteDataB[7:0];
        end
        if (writeCommit && (offset == 5'h18)) begin
            countClear = 1'b1;
        end
    end

    // Handshake: ack is driven out one cycle after the commit edge, from the held result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            registerAckB      <= 1'b0;
            registerErrorB    <= 1'b0;
            registerReadDataB <= 32'h0;
        end else begin
            registerAckB      <= 1'b0;
            registerErrorB    <= 1'b0;
            registerReadDataB <= 32'h0;
            case (state)
                IDLE: begin
                    if (registerSelectB) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= registerSelectB ? ACK : IDLE;
                end
                ACK: begin
                    state             <= RELEASE;
                    registerAckB      <= 1'b1;
                    registerErrorB    <= holdError;
                    registerReadDataB <= holdData;
                end
                RELEASE: begin
                    if (!registerSelectB) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            holdError <= accessError;
            holdData  <= (registerReadB && !accessError) ? readValue : 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scratch    <= 32'h0;
            control    <= 8'h00;
            intEnable  <= 8'h00;
            intStatus  <= 8'h00;
            eventCount <= 32'h0;
            intOut     <= 1'b0;
        end else begin
            if (writeCommit && (offset == 5'h04)) begin
                scratch <= registerWriteDataB;
            end
            if (writeCommit && (offset == 5'h08)) begin
                control <= registerWriteDataB[7:0];
            end
            if (writeCommit && (offset == 5'h14)) begin
                intEnable <= registerWriteDataB[7:0];
            end
            // A new event wins over a same-cycle W1C clear of that bit.
            intStatus  <= (intStatus & ~intClearMask) | intEvent;
            eventCount <= (countClear ? 32'h0 : eventCount) + {28'h0, popCount(intEvent)};
            intOut     <= |(intStatus & intEnable);
        end
    end

endmodule

// File: tb/tb_ip_reg_target.sv
// Bench for ip_reg_target: directed scenarios plus randomized accesses and events,
// checked against a register-level model of the map kept here.
module tb_ip_reg_target;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] IDV  = 32'h5043_4944;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        registerSelectB = 1'b0;
    logic        registerReadB = 1'b0;
    logic [31:0] registerAddressB = 32'h0;
    logic [31:0] registerWriteDataB = 32'h0;
    logic        registerAckB;
    logic        registerErrorB;
    logic [31:0] registerReadDataB;
    logic [31:0] statusIn = 32'h0;
    logic [7:0]  intEvent = 8'h00;
    logic [7:0]  control;
    logic        intOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] mScratch = 32'h0;
    logic [7:0]  mControl = 8'h00;
    logic [7:0]  mIntStatus = 8'h00;
    logic [7:0]  mIntEnable = 8'h00;
    logic [31:0] mEventCount = 32'h0;
    logic        expIntOut = 1'b0;
    logic        expErr = 1'b0;
    logic [31:0] expRdata = 32'h0;
    bit          evMode = 1'b0;

    ip_reg_target #(.BASE_ADDR(BASE), .ID_VALUE(IDV)) dut (
        .clock(clock),
        .reset(reset),
        .registerSelectB(registerSelectB),
        .registerReadB(registerReadB),
        .registerAddressB(registerAddressB),
        .registerWriteDataB(registerWriteDataB),
        .registerAckB(registerAckB),
        .registerErrorB(registerErrorB),
        .registerReadDataB(registerReadDataB),
        .statusIn(statusIn),
        .intEvent(intEvent),
        .control(control),
        .intOut(intOut)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic resetModel();
        mScratch = 32'h0;
        mControl = 8'h00;
        mIntStatus = 8'h00;
        mIntEnable = 8'h00;
        mEventCount = 32'h0;
        expIntOut = 1'b0;
    endtask

    // One clock edge; the model applies the access (if commit) and this cycle's events.
    task automatic tick(input bit commit);
        logic [7:0]  ev;
        logic [7:0]  clrMask;
        bit          clrCnt;
        logic [4:0]  off;
        bit          err;
        logic [31:0] rv;
        ev = intEvent;
        clrMask = 8'h00;
        clrCnt = 1'b0;
        @(posedge clock);
        expIntOut = |(mIntStatus & mIntEnable);
        if (commit) begin
            off = registerAddressB[4:0];
            err = (registerAddressB[31:5] != BASE[31:5]) || (off[1:0] != 2'b00) || (off == 5'h1C)
                  || (!registerReadB && (off == 5'h00 || off == 5'h0C));
            rv = 32'h0;
            if (registerReadB && !err) begin
                case (off)
                    5'h00: rv = IDV;
                    5'h04: rv = mScratch;
                    5'h08: rv = {24'h0, mControl};
                    5'h0C: rv = statusIn;
                    5'h10: rv = {24'h0, mIntStatus};
                    5'h14: rv = {24'h0, mIntEnable};
                    5'h18: rv = mEventCount;
                    default: rv = 32'h0;
                endcase
            end
            if (!registerReadB && !err) begin
                case (off)
                    5'h04: mScratch = registerWriteDataB;
                    5'h08: mControl = registerWriteDataB[7:0];
                    5'h10: clrMask = registerWriteDataB[7:0];
                    5'h14: mIntEnable = registerWriteDataB[7:0];
                    5'h18: clrCnt = 1'b1;
                    default: ;
                endcase
            end
            expErr = err;
            expRdata = rv;
        end
        mIntStatus = (mIntStatus & ~clrMask) | ev;
        mEventCount = (clrCnt ? 32'h0 : mEventCount) + 32'($countones(ev));
        #1;
        checks++;
        if (control !== mControl) begin
            errors++;
            $display("FAIL control: got %h expected %h at %0t", control, mControl, $time);
        end
        checks++;
        if (intOut !== expIntOut) begin
            errors++;
            $display("FAIL intOut: got %b expected %b at %0t", intOut, expIntOut, $time);
        end
        intEvent = (evMode && $urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
    endtask

    task automatic do_access(input logic [31:0] addr, input bit rd, input logic [31:0] wdata,
                             input bit abort, input int hold, input logic [7:0] commitEv,
                             output logic [31:0] rdata, output bit gotErr);
        registerAddressB = addr;
        registerReadB = rd;
        registerWriteDataB = wdata;
        statusIn = $urandom;
        registerSelectB = 1'b1;
        rdata = 32'h0;
        gotErr = 1'b0;
        tick(0);
        checks++;
        if (registerAckB !== 1'b0) begin
            errors++;
            $display("FAIL ack_early_T: got %b expected 0 addr %h", registerAckB, addr);
        end
        if (abort) begin
            registerSelectB = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(0);
                checks++;
                if (registerAckB !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_ack: got %b expected 0 addr %h", registerAckB, addr);
                end
            end
        end else begin
            if (commitEv != 8'h00) intEvent = commitEv;
            tick(1);
            checks++;
            if (registerAckB !== 1'b0) begin
                errors++;
                $display("FAIL ack_early_T1: got %b expected 0 addr %h", registerAckB, addr);
            end
            tick(0);
            checks++;
            if (registerAckB !== 1'b1 || registerErrorB !== expErr || registerReadDataB !== expRdata) begin
                errors++;
                $display("FAIL ack_T2: got ack=%b err=%b data=%h expected ack=1 err=%b data=%h addr %h rd %b",
                         registerAckB, registerErrorB, registerReadDataB, expErr, expRdata, addr, rd);
            end
            rdata = registerReadDataB;
            gotErr = registerErrorB;
            for (int i = 0; i < hold; i++) begin
                tick(0);
                checks++;
                if (registerAckB !== 1'b0 || registerErrorB !== 1'b0 || registerReadDataB !== 32'h0) begin
                    errors++;
                    $display("FAIL hold_quiet: got ack=%b err=%b data=%h expected all 0",
                             registerAckB, registerErrorB, registerReadDataB);
                end
            end
            registerSelectB = 1'b0;
            tick(0);
            checks++;
            if (registerAckB !== 1'b0) begin
                errors++;
                $display("FAIL ack_after: got %b expected 0", registerAckB);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit e;
        #2;
        checks++;
        if (registerAckB !== 1'b0 || registerErrorB !== 1'b0 || registerReadDataB !== 32'h0
            || control !== 8'h00 || intOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b data=%h control=%h intOut=%b expected all 0",
                     registerAckB, registerErrorB, registerReadDataB, control, intOut);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        resetModel();
        do_access(BASE + 32'h00, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== IDV || e !== 1'b0) begin
            errors++;
            $display("FAIL read_id: got %h err %b expected %h err 0", d, e, IDV);
        end
        for (int k = 1; k < 7; k++) begin
            if (k == 3) continue;
            do_access(BASE + 32'(4 * k), 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg_%0d: got %h expected 0", k, d);
            end
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        bit e;
        do_access(BASE + 32'h04, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL scratch_write_err: got %b expected 0", e);
        end
        do_access(BASE + 32'h04, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL scratch_read: got %h err %b expected deadbeef err 0", d, e);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        bit e;
        logic [31:0] addrs [6];
        bit          rds [6];
        addrs = '{BASE + 32'h1C, BASE + 32'h06, BASE + 32'h00, BASE + 32'h0C, BASE + 32'h20, 32'h4000_1104};
        rds   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_access(addrs[i], rds[i], 32'h1234_5678, 1'b0, 0, 8'h00, d, e);
            checks++;
            if (e !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL error_access_%0d: got err %b data %h expected err 1 data 0", i, e, d);
            end
        end
        do_access(BASE + 32'h04, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL error_no_effect: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_interrupts();
        logic [31:0] d;
        bit e;
        do_access(BASE + 32'h14, 1'b0, 32'h01, 1'b0, 0, 8'h00, d, e);
        intEvent = 8'h01;
        tick(0);
        tick(0);
        checks++;
        if (intOut !== 1'b1) begin
            errors++;
            $display("FAIL intOut_set: got %b expected 1", intOut);
        end
        do_access(BASE + 32'h10, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h01) begin
            errors++;
            $display("FAIL int_status_read: got %h expected 01", d);
        end
        do_access(BASE + 32'h10, 1'b0, 32'h01, 1'b0, 0, 8'h01, d, e);
        do_access(BASE + 32'h10, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h01) begin
            errors++;
            $display("FAIL set_wins: got %h expected 01", d);
        end
        do_access(BASE + 32'h10, 1'b0, 32'h01, 1'b0, 0, 8'h00, d, e);
        do_access(BASE + 32'h10, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h00 || intOut !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: got %h intOut %b expected 00 intOut 0", d, intOut);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        bit e;
        do_access(BASE + 32'h08, 1'b0, 32'hFF, 1'b1, 0, 8'h00, d, e);
        checks++;
        if (control !== 8'h00) begin
            errors++;
            $display("FAIL abort_control: got %h expected 00", control);
        end
        do_access(BASE + 32'h04, 1'b0, 32'h0BAD_F00D, 1'b0, 5, 8'h00, d, e);
    endtask

    task automatic test_event_wrap();
        logic [31:0] d;
        bit e;
        force dut.eventCount = 32'hFFFF_FFFF;
        #1 release dut.eventCount;
        mEventCount = 32'hFFFF_FFFF;
        intEvent = 8'h03;
        tick(0);
        do_access(BASE + 32'h18, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL count_wrap: got %h expected 00000001", d);
        end
        do_access(BASE + 32'h18, 1'b0, 32'h5555, 1'b0, 0, 8'h03, d, e);
        do_access(BASE + 32'h18, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL count_clear_load: got %h expected 00000002", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] a;
        bit e;
        evMode = 1'b1;
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                8: a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
                9: begin
                    a = $urandom;
                    if (a[31:5] == BASE[31:5]) a[20] = ~a[20];
                end
                default: a = BASE + 32'(4 * $urandom_range(0, 7));
            endcase
            do_access(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2), 8'h00, d, e);
        end
        evMode = 1'b0;
        intEvent = 8'h00;
        tick(0);
    endtask

    task automatic test_reset_release();
        logic [31:0] d;
        bit e;
        do_access(BASE + 32'h08, 1'b0, 32'hA5, 1'b0, 0, 8'h00, d, e);
        registerAddressB = BASE + 32'h08;
        registerReadB = 1'b1;
        registerSelectB = 1'b1;
        tick(0);
        tick(1);
        tick(0);
        tick(0);
        reset = 1'b0;
        resetModel();
        #1;
        checks++;
        if (control !== 8'h00 || registerAckB !== 1'b0 || registerReadDataB !== 32'h0 || intOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_release: got control %h ack %b data %h intOut %b expected 00 0 0 0",
                     control, registerAckB, registerReadDataB, intOut);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        do_access(BASE + 32'h08, 1'b1, 32'h0, 1'b0, 0, 8'h00, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL restart_after_reset: got %h err %b expected 0 err 0", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_errors();
        test_interrupts();
        test_abort();
        test_event_wrap();
        test_random();
        test_reset_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
